// File: rtl/prog_mem_target.sv
// prog_mem_target: CPU bus-target memory with a host load port that holds the CPU in reset until an image is streamed in.
module prog_mem_target #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  rd,
  input  logic                  wr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  bus_err
);
  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   ld_count_q, ld_count_d;
  logic                  bus_err_q, bus_err_d;
  logic                  xfer, run, mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  assign run       = state_q == RUN;
  assign ld_ready  = state_q == LOAD;
  assign cpu_hold  = !run;
  assign load_done = run;
  assign ld_count  = ld_count_q;
  assign bus_err   = bus_err_q;
  assign data      = (run && rd && !wr) ? mem[addr] : {DATA_WIDTH{1'bz}};
  always_comb begin
    xfer       = ld_ready && ld_valid;
    state_d    = (state_q == START) ? RUN :
                 (xfer && (ld_last || ptr_q == LAST_PTR)) ? START : state_q;
    ptr_d      = xfer ? ptr_q + 1'b1 : ptr_q;
    ld_count_d = xfer ? ld_count_q + 1'b1 : ld_count_q;
    bus_err_d  = run && rd && wr;
    // A write racing reset is dropped so reset leaves storage untouched.
    mem_we     = !rst && (xfer || (run && wr));
    mem_waddr  = xfer ? ptr_q : addr;
    mem_wdata  = xfer ? ld_data : data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LOAD;
      ptr_q      <= '0;
      ld_count_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      ld_count_q <= ld_count_d;
      bus_err_q  <= bus_err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end
endmodule

// File: tb/tb_prog_mem_target.sv
// tb_prog_mem_target: directed vector bench for prog_mem_target load/run behaviour.
module tb_prog_mem_target;
  logic       clk = 1'b0;
  logic       rst, rd, wr, ld_valid, ld_last, tb_oe;
  logic [4:0] addr;
  logic [7:0] ld_data, tb_drv;
  wire  [7:0] data;
  logic       ld_ready, cpu_hold, load_done, bus_err;
  logic [5:0] ld_count;
  int         n_cmp = 0, n_fail = 0;

  assign data = tb_oe ? tb_drv : 8'bz;
  always #5 clk = ~clk;

  prog_mem_target dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data(data),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .ld_count(ld_count), .cpu_hold(cpu_hold),
    .load_done(load_done), .bus_err(bus_err)
  );

  typedef struct {
    logic       valid;
    logic [7:0] dat;
    logic       last;
    logic [5:0] exp_count;
    logic       exp_ready;
    logic       exp_hold;
    logic       exp_done;
  } ld_vec_t;

  typedef struct {
    logic [4:0] a;
    logic [7:0] exp;
  } rd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] exp);
    addr = a;
    rd   = 1'b1;
    wr   = 1'b0;
    #1;
    chk(name, {24'd0, data}, {24'd0, exp});
    rd = 1'b0;
  endtask

  ld_vec_t gap_tab [9];
  rd_vec_t rd_tab  [6];

  initial begin
    gap_tab[0] = '{1'b1, 8'hB0, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0};
    gap_tab[1] = '{1'b0, 8'hEE, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0};
    gap_tab[2] = '{1'b1, 8'hB1, 1'b0, 6'd2, 1'b1, 1'b1, 1'b0};
    gap_tab[3] = '{1'b0, 8'hEE, 1'b1, 6'd2, 1'b1, 1'b1, 1'b0};
    gap_tab[4] = '{1'b1, 8'hB2, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0};
    gap_tab[5] = '{1'b0, 8'hEE, 1'b0, 6'd3, 1'b1, 1'b1, 1'b0};
    gap_tab[6] = '{1'b1, 8'hB3, 1'b1, 6'd4, 1'b0, 1'b1, 1'b0};
    gap_tab[7] = '{1'b0, 8'hEE, 1'b0, 6'd4, 1'b0, 1'b0, 1'b1};
    gap_tab[8] = '{1'b1, 8'h99, 1'b1, 6'd4, 1'b0, 1'b0, 1'b1};
    rd_tab[0] = '{5'd0, 8'hA0};
    rd_tab[1] = '{5'd1, 8'hA1};
    rd_tab[2] = '{5'd2, 8'hA2};
    rd_tab[3] = '{5'd3, 8'hA3};
    rd_tab[4] = '{5'd4, 8'hA4};
    rd_tab[5] = '{5'd3, 8'hA3};
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; tb_oe = 1'b0; tb_drv = '0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    cyc();

    // Reset state
    do_reset();
    chk("rst_ready", ld_ready, 1);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", load_done, 0);
    chk("rst_err", bus_err, 0);
    chk("rst_count", ld_count, 0);

    // Back-to-back 5-byte load with last
    for (int i = 0; i < 5; i++) load_byte(8'hA0 + 8'(i), i == 4);
    chk("t1_count", ld_count, 5);
    chk("t1_start_hold", cpu_hold, 1);
    chk("t1_start_ready", ld_ready, 0);
    chk("t1_start_done", load_done, 0);
    cyc();
    chk("t1_run_hold", cpu_hold, 0);
    chk("t1_run_done", load_done, 1);
    chk("t1_run_count", ld_count, 5);
    for (int i = 0; i < 6; i++) rd_chk($sformatf("t1_rd%0d", i), rd_tab[i].a, rd_tab[i].exp);

    // Write then read back; bus released while rd is low
    addr = 5'd7; wr = 1'b1; tb_oe = 1'b1; tb_drv = 8'h5C;
    cyc();
    wr = 1'b0; tb_oe = 1'b0;
    rd_chk("t4_rd7", 5'd7, 8'h5C);
    addr = 5'd3; tb_oe = 1'b1; tb_drv = 8'h00;
    #1;
    chk("t4_hiz", {24'd0, data}, 32'h0);
    tb_oe = 1'b0;

    // rd and wr together
    addr = 5'd2; rd = 1'b1; wr = 1'b1; tb_oe = 1'b1; tb_drv = 8'h11;
    #1;
    chk("t5_nodrive", {24'd0, data}, 32'h11);
    chk("t5_err_pre", bus_err, 0);
    cyc();
    rd = 1'b0; wr = 1'b0; tb_oe = 1'b0;
    chk("t5_err_hi", bus_err, 1);
    cyc();
    chk("t5_err_lo", bus_err, 0);
    rd_chk("t5_rd2", 5'd2, 8'h11);

    // Gapped load, table driven
    do_reset();
    chk("t2_rst_count", ld_count, 0);
    for (int i = 0; i < 9; i++) begin
      ld_valid = gap_tab[i].valid;
      ld_data  = gap_tab[i].dat;
      ld_last  = gap_tab[i].last;
      cyc();
      chk($sformatf("t2_count%0d", i), ld_count, gap_tab[i].exp_count);
      chk($sformatf("t2_ready%0d", i), ld_ready, gap_tab[i].exp_ready);
      chk($sformatf("t2_hold%0d", i), cpu_hold, gap_tab[i].exp_hold);
      chk($sformatf("t2_done%0d", i), load_done, gap_tab[i].exp_done);
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    for (int i = 0; i < 4; i++) rd_chk($sformatf("t2_rd%0d", i), 5'(i), 8'hB0 + 8'(i));
    rd_chk("t2_rd4_kept", 5'd4, 8'hA4);

    // Reset mid-load, then a short reload; CPU strobes ignored during load
    do_reset();
    rd = 1'b1; wr = 1'b1; addr = 5'd2;
    for (int i = 0; i < 3; i++) begin
      load_byte(8'hC0 + 8'(i), 1'b0);
      chk($sformatf("t6_hold_a%0d", i), cpu_hold, 1);
      chk($sformatf("t6_err_a%0d", i), bus_err, 0);
    end
    chk("t6_count3", ld_count, 3);
    do_reset();
    chk("t6_rst_count", ld_count, 0);
    chk("t6_rst_hold", cpu_hold, 1);
    rd = 1'b0; wr = 1'b0;
    load_byte(8'hF0, 1'b0);
    chk("t6_hold_b0", cpu_hold, 1);
    load_byte(8'hF1, 1'b1);
    chk("t6_hold_b1", cpu_hold, 1);
    chk("t6_count", ld_count, 2);
    cyc();
    chk("t6_run", load_done, 1);
    rd_chk("t6_rd0", 5'd0, 8'hF0);
    rd_chk("t6_rd1", 5'd1, 8'hF1);
    rd_chk("t6_rd2_kept", 5'd2, 8'hC2);

    // Full-depth load with no last, then excess valid bytes
    do_reset();
    ld_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ld_data = 8'(i);
      cyc();
      if (i == 30) chk("t3_ready31", ld_ready, 1);
    end
    chk("t3_ready_end", ld_ready, 0);
    chk("t3_hold_start", cpu_hold, 1);
    ld_data = 8'hEE;
    for (int i = 0; i < 3; i++) cyc();
    ld_valid = 1'b0;
    chk("t3_count", ld_count, 32);
    chk("t3_ready_after", ld_ready, 0);
    chk("t3_done", load_done, 1);
    rd_chk("t3_rd31", 5'd31, 8'h1F);
    rd_chk("t3_rd0", 5'd0, 8'h00);
    rd_chk("t3_rd5", 5'd5, 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
